// File: rtl/eda_pkg.sv
// rtl/eda_pkg.sv - shared configuration and state encoding for the eda pixel loader
package eda_pkg;

    localparam int CFG_M           = 4;
    localparam int CFG_N           = 4;
    localparam int CFG_PIXEL_WIDTH = 8;
    localparam int CFG_I_WIDTH     = (CFG_M > 1) ? $clog2(CFG_M) : 1;
    localparam int CFG_J_WIDTH     = (CFG_N > 1) ? $clog2(CFG_N) : 1;
    localparam int CFG_ADDR_WIDTH  = CFG_I_WIDTH + CFG_J_WIDTH;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/eda_rc_counter.sv
// rtl/eda_rc_counter.sv - raster row/column counter with clear, enable, wrap and last flag
module eda_rc_counter
    import eda_pkg::*;
#(
    parameter int ROWS    = CFG_M,
    parameter int COLS    = CFG_N,
    parameter int I_WIDTH = CFG_I_WIDTH,
    parameter int J_WIDTH = CFG_J_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [I_WIDTH-1:0] i_o,
    output logic [J_WIDTH-1:0] j_o,
    output logic               last_o
);

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(ROWS - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(COLS - 1);

    logic [I_WIDTH-1:0] i_q, i_d;
    logic [J_WIDTH-1:0] j_q, j_d;

    // Clear wins over enable so an aborted frame restarts at {0,0}.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
        end else if (en_i) begin
            if (j_q == J_LAST) begin
                j_d = '0;
                i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i_o    = i_q;
    assign j_o    = j_q;
    assign last_o = (i_q == I_LAST) && (j_q == J_LAST);

endmodule

// File: rtl/eda_pixel_loader.sv
// rtl/eda_pixel_loader.sv - raster pixel stream to image RAM loader with start/done handshake
module eda_pixel_loader
    import eda_pkg::*;
#(
    parameter int M           = CFG_M,
    parameter int N           = CFG_N,
    parameter int PIXEL_WIDTH = CFG_PIXEL_WIDTH,
    parameter int I_WIDTH     = CFG_I_WIDTH,
    parameter int J_WIDTH     = CFG_J_WIDTH,
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    input  logic                   s_last,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   write_en,
    output logic                   start,
    input  logic                   done,
    output logic                   busy,
    output logic                   frame_err
);

    loader_state_t          state_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [PIXEL_WIDTH-1:0] pixel_q;
    logic                   write_en_q;
    logic                   start_q;
    logic                   busy_q;
    logic                   frame_err_q;

    logic [I_WIDTH-1:0] cnt_i;
    logic [J_WIDTH-1:0] cnt_j;
    logic               cnt_last;
    logic               beat;
    logic               cnt_clr;

    assign s_ready = reset_n && (state_q == LOAD);
    assign beat    = s_valid && s_ready;
    // A premature s_last aborts the frame; the final beat wraps the counters anyway.
    assign cnt_clr = beat && (cnt_last || s_last);

    eda_rc_counter #(
        .ROWS    (M),
        .COLS    (N),
        .I_WIDTH (I_WIDTH),
        .J_WIDTH (J_WIDTH)
    ) u_rc_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (beat),
        .i_o     (cnt_i),
        .j_o     (cnt_j),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            wr_addr_q   <= '0;
            pixel_q     <= '0;
            write_en_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            write_en_q  <= 1'b0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (beat) begin
                        write_en_q <= 1'b1;
                        wr_addr_q  <= {cnt_i, cnt_j};
                        pixel_q    <= s_pixel;
                        if (cnt_last) begin
                            state_q     <= DRAIN;
                            frame_err_q <= !s_last;
                        end else if (s_last) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= START;
                    start_q <= 1'b1;
                end
                START: begin
                    state_q <= WAIT;
                    busy_q  <= 1'b1;
                end
                WAIT: begin
                    if (done) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LOAD;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr   = wr_addr_q;
    assign pixel_out = pixel_q;
    assign write_en  = write_en_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_eda_pixel_loader.sv
// tb/tb_eda_pixel_loader.sv - directed table and sequence bench for eda_pixel_loader
module tb_eda_pixel_loader;

    logic       clk;
    logic       reset_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pixel;
    logic       s_last;
    logic [3:0] wr_addr;
    logic [7:0] pixel_out;
    logic       write_en;
    logic       start;
    logic       done;
    logic       busy;
    logic       frame_err;

    eda_pixel_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
        .s_last    (s_last),
        .wr_addr   (wr_addr),
        .pixel_out (pixel_out),
        .write_en  (write_en),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] p;
        logic       l;
        logic       d;
        logic       we;
        logic [3:0] addr;
        logic       st;
        logic       bsy;
        logic       rdy;
        logic       err;
    } vec_t;

    vec_t tbl [20];

    int checks;
    int failures;
    int wr_cnt;
    int start_cnt;
    int err_cnt;
    logic [3:0] exp_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, then observe registered outputs just after the edge.
    task automatic cyc(input logic v, input logic [7:0] p, input logic l, input logic d);
        s_valid = v;
        s_pixel = p;
        s_last  = l;
        done    = d;
        @(posedge clk);
        #1;
        if (write_en) begin
            chk("wr_addr_seq", 32'(wr_addr), 32'(exp_next));
            chk("pixel_out_seq", 32'(pixel_out), 32'(exp_next));
            exp_next = exp_next + 4'd1;
            wr_cnt++;
        end
        if (start) start_cnt++;
        if (frame_err) err_cnt++;
    endtask

    task automatic clear_counts();
        wr_cnt    = 0;
        start_cnt = 0;
        err_cnt   = 0;
        exp_next  = 4'd0;
    endtask

    task automatic full_frame(input logic with_last);
        for (int k = 0; k < 16; k++) cyc(1'b1, 8'(k), (k == 15) ? with_last : 1'b0, 1'b0);
    endtask

    initial begin
        int bad;
        checks   = 0;
        failures = 0;
        clear_counts();
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_pixel = 8'h00;
        s_last  = 1'b0;
        done    = 1'b0;

        for (int k = 0; k < 16; k++) begin
            tbl[k].v = 1'b1; tbl[k].p = 8'(k); tbl[k].l = (k == 15); tbl[k].d = 1'b0;
            tbl[k].we = 1'b1; tbl[k].addr = 4'(k); tbl[k].st = 1'b0; tbl[k].bsy = 1'b0;
            tbl[k].rdy = (k != 15); tbl[k].err = 1'b0;
        end
        // START cycle; done during DRAIN ignored
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        // done during START must not end WAIT
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};

        #23;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_s_ready", 32'(s_ready), 32'd1);

        // Test 1: back-to-back frame, table driven
        clear_counts();
        for (int r = 0; r < 20; r++) begin
            cyc(tbl[r].v, tbl[r].p, tbl[r].l, tbl[r].d);
            chk($sformatf("t1_we[%0d]", r), 32'(write_en), 32'(tbl[r].we));
            chk($sformatf("t1_start[%0d]", r), 32'(start), 32'(tbl[r].st));
            chk($sformatf("t1_busy[%0d]", r), 32'(busy), 32'(tbl[r].bsy));
            chk($sformatf("t1_ready[%0d]", r), 32'(s_ready), 32'(tbl[r].rdy));
            chk($sformatf("t1_err[%0d]", r), 32'(frame_err), 32'(tbl[r].err));
            if (tbl[r].we) chk($sformatf("t1_addr[%0d]", r), 32'(wr_addr), 32'(tbl[r].addr));
        end
        chk("t1_start_cnt", 32'(start_cnt), 32'd1);

        // Test 2: alternating valid
        clear_counts();
        for (int k = 0; k < 32; k++) cyc(k % 2 == 0, 8'(k / 2), k == 30, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_writes", 32'(wr_cnt), 32'd16);
        chk("t2_start_cnt", 32'(start_cnt), 32'd1);
        chk("t2_err_cnt", 32'(err_cnt), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_back_to_load", 32'(s_ready), 32'd1);

        // Test 3: premature s_last on beat 5
        clear_counts();
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(k), k == 4, 1'b0);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_ready_after_err", 32'(s_ready), 32'd1);
        exp_next = 4'd0;
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("t3_restart_addr", 32'(wr_addr), 32'd0);
        chk("t3_err_pulse_once", 32'(frame_err), 32'd0);
        chk("t3_no_start_yet", 32'(start_cnt), 32'd0);
        for (int k = 1; k < 16; k++) cyc(1'b1, 8'(k), k == 15, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_start_cnt", 32'(start_cnt), 32'd1);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Test 4: final beat without s_last
        clear_counts();
        full_frame(1'b0);
        chk("t4_frame_err", 32'(frame_err), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_start", 32'(start), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_start_cnt", 32'(start_cnt), 32'd1);
        chk("t4_err_cnt", 32'(err_cnt), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Test 5: long wait for done, then second frame
        clear_counts();
        full_frame(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b1, 8'hAA, 1'b0, 1'b0);
            if (s_ready !== 1'b0 || busy !== 1'b1 || write_en !== 1'b0) bad++;
        end
        chk("t5_wait_hold_bad_cycles", 32'(bad), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_ready_after_done", 32'(s_ready), 32'd1);
        chk("t5_busy_after_done", 32'(busy), 32'd0);
        exp_next = 4'd0;
        full_frame(1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_start_cnt", 32'(start_cnt), 32'd2);
        chk("t5_writes", 32'(wr_cnt), 32'd32);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Test 6: reset mid-frame
        clear_counts();
        for (int k = 0; k < 7; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_write_en", 32'(write_en), 32'd0);
        chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6_rst_pixel_out", 32'(pixel_out), 32'd0);
        chk("t6_rst_s_ready", 32'(s_ready), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_counts();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        chk("t6_first_addr", 32'(wr_addr), 32'd0);
        for (int k = 1; k < 16; k++) cyc(1'b1, 8'(k), k == 15, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_start_cnt", 32'(start_cnt), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
